// File: rtl/csr_bus_if.sv
// Register-side bus between the APB4 bridge (master) and a register block (slave).
// Handshake: bus_req is held high with stable fields until the slave pulses
// bus_ready for one cycle; bus_rd_data/bus_err are meaningful only on that cycle.
interface csr_bus_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic                      bus_req;
    logic                      bus_req_is_wr;
    logic [ADDR_WIDTH-1:0]     bus_addr;
    logic [DATA_WIDTH-1:0]     bus_wr_data;
    logic [DATA_WIDTH/8-1:0]   bus_wr_biten;
    logic                      bus_ready;
    logic [DATA_WIDTH-1:0]     bus_rd_data;
    logic                      bus_err;

    modport master (
        output bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
        input  bus_ready, bus_rd_data, bus_err
    );

    modport slave (
        input  bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
        output bus_ready, bus_rd_data, bus_err
    );
endinterface

// File: rtl/csr_regblock.sv
// Four-CSR register bank (CTRL, STATUS, IRQ_STAT W1C, IRQ_EN) behind the bridge's
// register bus, with a registered level interrupt and optional response wait states.
module csr_regblock #(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    csr_bus_if.slave              bus,
    input  logic [DATA_WIDTH-1:0] hw_status,
    input  logic [DATA_WIDTH-1:0] hw_irq_set,
    output logic [DATA_WIDTH-1:0] ctrl_out,
    output logic                  irq,
    output logic [1:0]            state_dbg
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_STAT   = 2'd2;
    localparam logic [1:0] OFF_EN     = 2'd3;

    logic [1:0]            state_q;
    logic [3:0]            wait_cnt_q;
    logic [DATA_WIDTH-1:0] ctrl_q;
    logic [DATA_WIDTH-1:0] irq_stat_q;
    logic [DATA_WIDTH-1:0] irq_en_q;
    logic                  irq_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  err_q;

    logic                  accept;
    logic [1:0]            reg_off;
    logic                  acc_err;
    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] be_mask;
    logic [DATA_WIDTH-1:0] w1c_clr;
    logic [DATA_WIDTH-1:0] rd_mux;

    // Only bits [3:0] decode; anything above aliases onto the same four registers.
    assign accept  = (state_q == S_IDLE) && bus.bus_req;
    assign reg_off = bus.bus_addr[3:2];
    assign acc_err = (bus.bus_addr[1:0] != 2'b00) ||
                     (bus.bus_req_is_wr && (reg_off == OFF_STATUS));
    assign wr_ok   = accept && bus.bus_req_is_wr && !acc_err;

    always_comb begin
        be_mask = '0;
        for (int k = 0; k < DATA_WIDTH/8; k++) begin
            be_mask[k*8 +: 8] = {8{bus.bus_wr_biten[k]}};
        end
    end

    assign w1c_clr = (wr_ok && (reg_off == OFF_STAT)) ? (bus.bus_wr_data & be_mask) : '0;

    always_comb begin
        rd_mux = '0;
        if (!bus.bus_req_is_wr && !acc_err) begin
            case (reg_off)
                OFF_CTRL:   rd_mux = ctrl_q;
                OFF_STATUS: rd_mux = hw_status;
                OFF_STAT:   rd_mux = irq_stat_q;
                default:    rd_mux = irq_en_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            ctrl_q     <= '0;
            irq_stat_q <= '0;
            irq_en_q   <= '0;
            irq_q      <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            // Hardware set is OR-ed in after the clear so it wins on a collision.
            irq_stat_q <= (irq_stat_q & ~w1c_clr) | hw_irq_set;
            irq_q      <= |(irq_stat_q & irq_en_q);

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        rd_data_q <= rd_mux;
                        err_q     <= acc_err;
                        if (wr_ok && (reg_off == OFF_CTRL)) begin
                            ctrl_q <= (ctrl_q & ~be_mask) | (bus.bus_wr_data & be_mask);
                        end
                        if (wr_ok && (reg_off == OFF_EN)) begin
                            irq_en_q <= (irq_en_q & ~be_mask) | (bus.bus_wr_data & be_mask);
                        end
                        if (WAIT_CYCLES > 0) begin
                            state_q    <= S_WAIT;
                            wait_cnt_q <= WAIT_LOAD;
                        end else begin
                            state_q <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_q == 4'd0) begin
                        state_q <= S_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                // bus_req is still high here; returning to IDLE without accepting
                // keeps the same request from executing twice.
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.bus_ready   = (state_q == S_RESP);
    assign bus.bus_rd_data = (state_q == S_RESP) ? rd_data_q : '0;
    assign bus.bus_err     = (state_q == S_RESP) ? err_q : 1'b0;
    assign ctrl_out        = ctrl_q;
    assign irq             = irq_q;
    assign state_dbg       = state_q;
endmodule

// File: tb/tb_csr_regblock.sv
// Directed bench for csr_regblock: one zero-wait instance and one WAIT_CYCLES=3 instance.
module tb_csr_regblock;
    logic        clk;
    logic        rst;
    logic [31:0] hw_status;
    logic [31:0] hw_irq_set;
    logic [31:0] ctrl_out0, ctrl_out3;
    logic        irq0, irq3;
    logic [1:0]  state0, state3;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    csr_bus_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus0 ();
    csr_bus_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus3 ();

    csr_regblock #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave), .hw_status(hw_status),
        .hw_irq_set(hw_irq_set), .ctrl_out(ctrl_out0), .irq(irq0), .state_dbg(state0)
    );

    csr_regblock #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3.slave), .hw_status(hw_status),
        .hw_irq_set(hw_irq_set), .ctrl_out(ctrl_out3), .irq(irq3), .state_dbg(state3)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_req(input int sel, input logic req, input logic wr,
                             input logic [3:0] addr, input logic [31:0] wdata,
                             input logic [3:0] biten);
        if (sel == 0) begin
            bus0.bus_req = req; bus0.bus_req_is_wr = wr; bus0.bus_addr = addr;
            bus0.bus_wr_data = wdata; bus0.bus_wr_biten = biten;
        end else begin
            bus3.bus_req = req; bus3.bus_req_is_wr = wr; bus3.bus_addr = addr;
            bus3.bus_wr_data = wdata; bus3.bus_wr_biten = biten;
        end
    endtask

    function automatic logic ready_of(input int sel);
        return (sel == 0) ? bus0.bus_ready : bus3.bus_ready;
    endfunction

    // Driver: issue one request, hold it until bus_ready has been seen and the
    // following edge has passed, then watch for any stray extra responses.
    task automatic xfer(input int sel, input logic wr, input logic [3:0] addr,
                        input logic [31:0] wdata, input logic [3:0] biten,
                        input logic [31:0] irq_pulse,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int extra);
        logic got;
        got = 1'b0; rdata = '0; err = 1'b0; lat = 0; extra = 0;
        @(negedge clk);
        drive_req(sel, 1'b1, wr, addr, wdata, biten);
        hw_irq_set = irq_pulse;
        while (!got && lat < 40) begin
            @(negedge clk);
            hw_irq_set = '0;
            lat++;
            if (ready_of(sel)) begin
                got   = 1'b1;
                rdata = (sel == 0) ? bus0.bus_rd_data : bus3.bus_rd_data;
                err   = (sel == 0) ? bus0.bus_err : bus3.bus_err;
            end
        end
        if (!got) begin
            n_checks++; n_errors++;
            $display("FAIL xfer_timeout: addr=%h no bus_ready within %0d cycles", addr, lat);
        end
        @(posedge clk);
        #1 drive_req(sel, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        repeat (8) begin
            @(negedge clk);
            if (ready_of(sel)) extra++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (ctrl_out0 !== 32'h0 || irq0 !== 1'b0 || state0 !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_regs: ctrl=%h irq=%b state=%0d want 0/0/0", ctrl_out0, irq0, state0);
        end
        n_checks++;
        if (bus0.bus_ready !== 1'b0 || bus0.bus_rd_data !== 32'h0 || bus0.bus_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_bus: ready=%b rd=%h err=%b want 0", bus0.bus_ready, bus0.bus_rd_data, bus0.bus_err);
        end
        n_checks++;
        if (bus3.bus_ready !== 1'b0 || ctrl_out3 !== 32'h0 || irq3 !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_dut3: ready=%b ctrl=%h irq=%b want 0", bus3.bus_ready, ctrl_out3, irq3);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_reads();
        logic [31:0] rd, exp;
        logic        err;
        int          lat, extra;
        logic [3:0]  addrs [3];
        addrs[0] = 4'h0; addrs[1] = 4'h8; addrs[2] = 4'hC;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'h0);
            xfer(0, 1'b0, addrs[i], 32'h0, 4'h0, 32'h0, rd, err, lat, extra);
            exp = exp_q.pop_front();
            n_checks++;
            if (rd !== exp || err !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_read_%h: rd=%h err=%b want %h/0", addrs[i], rd, err, exp);
            end
            n_checks++;
            if (lat !== 1 || extra !== 0) begin
                n_errors++;
                $display("FAIL reset_read_timing_%h: latency=%0d extra=%0d want 1/0", addrs[i], lat, extra);
            end
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd, exp;
        logic        err;
        int          lat, extra;
        xfer(0, 1'b1, 4'h0, 32'hA5A5_1234, 4'b0101, 32'h0, rd, err, lat, extra);
        n_checks++;
        if (ctrl_out0 !== 32'h00A5_0034 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL be_write: ctrl=%h err=%b want 00a50034/0", ctrl_out0, err);
        end
        exp_q.push_back(32'h00A5_0034);
        xfer(0, 1'b0, 4'h0, 32'h0, 4'h0, 32'h0, rd, err, lat, extra);
        exp = exp_q.pop_front();
        n_checks++;
        if (rd !== exp || err !== 1'b0) begin
            n_errors++;
            $display("FAIL be_readback: rd=%h err=%b want %h/0", rd, err, exp);
        end
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        logic        err;
        int          lat, extra;
        @(negedge clk);
        hw_irq_set = 32'h0000_0009;
        @(negedge clk);
        hw_irq_set = 32'h0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (irq0 !== 1'b0) begin
            n_errors++;
            $display("FAIL irq_masked: irq=%b want 0", irq0);
        end
        xfer(0, 1'b1, 4'hC, 32'h0000_0001, 4'hF, 32'h0, rd, err, lat, extra);
        n_checks++;
        if (irq0 !== 1'b1) begin
            n_errors++;
            $display("FAIL irq_enabled: irq=%b want 1", irq0);
        end
        xfer(0, 1'b0, 4'h8, 32'h0, 4'h0, 32'h0, rd, err, lat, extra);
        n_checks++;
        if (rd !== 32'h0000_0009) begin
            n_errors++;
            $display("FAIL irq_stat_set: rd=%h want 00000009", rd);
        end
        xfer(0, 1'b1, 4'h8, 32'h0000_0001, 4'hF, 32'h0, rd, err, lat, extra);
        n_checks++;
        if (irq0 !== 1'b0) begin
            n_errors++;
            $display("FAIL irq_after_clear: irq=%b want 0", irq0);
        end
        xfer(0, 1'b0, 4'h8, 32'h0, 4'h0, 32'h0, rd, err, lat, extra);
        n_checks++;
        if (rd !== 32'h0000_0008) begin
            n_errors++;
            $display("FAIL irq_stat_w1c: rd=%h want 00000008", rd);
        end
    endtask

    task automatic test_set_wins();
        logic [31:0] rd;
        logic        err;
        int          lat, extra;
        xfer(0, 1'b1, 4'h8, 32'h0000_0008, 4'hF, 32'h0000_0008, rd, err, lat, extra);
        xfer(0, 1'b0, 4'h8, 32'h0, 4'h0, 32'h0, rd, err, lat, extra);
        n_checks++;
        if (rd !== 32'h0000_0008) begin
            n_errors++;
            $display("FAIL set_wins: rd=%h want 00000008", rd);
        end
        // Byte enable gates the clear: byte 0 disabled leaves bit 3 set.
        xfer(0, 1'b1, 4'h8, 32'h0000_0008, 4'b1110, 32'h0, rd, err, lat, extra);
        xfer(0, 1'b0, 4'h8, 32'h0, 4'h0, 32'h0, rd, err, lat, extra);
        n_checks++;
        if (rd !== 32'h0000_0008) begin
            n_errors++;
            $display("FAIL w1c_biten: rd=%h want 00000008", rd);
        end
        xfer(0, 1'b1, 4'h8, 32'h0000_0008, 4'hF, 32'h0, rd, err, lat, extra);
        xfer(0, 1'b0, 4'h8, 32'h0, 4'h0, 32'h0, rd, err, lat, extra);
        n_checks++;
        if (rd !== 32'h0000_0000) begin
            n_errors++;
            $display("FAIL w1c_final: rd=%h want 00000000", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        err;
        int          lat, extra;
        xfer(0, 1'b1, 4'h4, 32'h1111_1111, 4'hF, 32'h0, rd, err, lat, extra);
        n_checks++;
        if (err !== 1'b1 || rd !== 32'h0) begin
            n_errors++;
            $display("FAIL err_status_write: err=%b rd=%h want 1/0", err, rd);
        end
        hw_status = 32'h1234_5678;
        xfer(0, 1'b0, 4'h2, 32'h0, 4'h0, 32'h0, rd, err, lat, extra);
        n_checks++;
        if (err !== 1'b1 || rd !== 32'h0) begin
            n_errors++;
            $display("FAIL err_misaligned_read: err=%b rd=%h want 1/0", err, rd);
        end
        xfer(0, 1'b1, 4'h1, 32'hFFFF_FFFF, 4'hF, 32'h0, rd, err, lat, extra);
        n_checks++;
        if (err !== 1'b1 || ctrl_out0 !== 32'h00A5_0034) begin
            n_errors++;
            $display("FAIL err_misaligned_write: err=%b ctrl=%h want 1/00a50034", err, ctrl_out0);
        end
        hw_status = 32'hDEAD_BEEF;
        xfer(0, 1'b0, 4'h4, 32'h0, 4'h0, 32'h0, rd, err, lat, extra);
        n_checks++;
        if (err !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL status_read: err=%b rd=%h want 0/deadbeef", err, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        err;
        int          lat, extra;
        xfer(0, 1'b1, 4'hC, 32'h0000_00F0, 4'hF, 32'h0, rd, err, lat, extra);
        xfer(0, 1'b0, 4'hC, 32'h0, 4'h0, 32'h0, rd, err, lat, extra);
        n_checks++;
        if (rd !== 32'h0000_00F0 || lat !== 1 || extra !== 0) begin
            n_errors++;
            $display("FAIL irq_en_rw: rd=%h lat=%0d extra=%0d want 000000f0/1/0", rd, lat, extra);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        logic        err;
        int          lat, extra;
        xfer(3, 1'b1, 4'h0, 32'h1234_5678, 4'hF, 32'h0, rd, err, lat, extra);
        n_checks++;
        if (lat !== 4 || extra !== 0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL wait_write_timing: lat=%0d extra=%0d err=%b want 4/0/0", lat, extra, err);
        end
        n_checks++;
        if (ctrl_out3 !== 32'h1234_5678) begin
            n_errors++;
            $display("FAIL wait_write_value: ctrl=%h want 12345678", ctrl_out3);
        end
        xfer(3, 1'b0, 4'h0, 32'h0, 4'h0, 32'h0, rd, err, lat, extra);
        n_checks++;
        if (rd !== 32'h1234_5678 || lat !== 4 || extra !== 0) begin
            n_errors++;
            $display("FAIL wait_read: rd=%h lat=%0d extra=%0d want 12345678/4/0", rd, lat, extra);
        end
    endtask

    task automatic test_reset_mid_wait();
        int stray;
        stray = 0;
        @(negedge clk);
        drive_req(3, 1'b1, 1'b1, 4'h0, 32'hFFFF_0000, 4'hF);
        @(negedge clk);
        n_checks++;
        if (state3 !== 2'd1 || ctrl_out3 !== 32'hFFFF_0000) begin
            n_errors++;
            $display("FAIL mid_wait_state: state=%0d ctrl=%h want 1/ffff0000", state3, ctrl_out3);
        end
        rst = 1'b1;
        drive_req(3, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        @(negedge clk);
        n_checks++;
        if (bus3.bus_ready !== 1'b0 || bus3.bus_rd_data !== 32'h0 || bus3.bus_err !== 1'b0 ||
            ctrl_out3 !== 32'h0 || irq3 !== 1'b0 || state3 !== 2'd0) begin
            n_errors++;
            $display("FAIL mid_wait_reset: ready=%b rd=%h err=%b ctrl=%h irq=%b state=%0d want all 0",
                     bus3.bus_ready, bus3.bus_rd_data, bus3.bus_err, ctrl_out3, irq3, state3);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus3.bus_ready) stray++;
        end
        n_checks++;
        if (stray !== 0) begin
            n_errors++;
            $display("FAIL mid_wait_no_ready: pulses=%0d want 0", stray);
        end
    endtask

    initial begin
        rst        = 1'b1;
        hw_status  = 32'h0;
        hw_irq_set = 32'h0;
        drive_req(0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        drive_req(3, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        test_reset();
        test_reset_reads();
        test_byte_enable();
        test_irq();
        test_set_wins();
        test_errors();
        test_back_to_back();
        test_wait_states();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/csr_regblock.md
Name: csr_regblock

Overview:
- Register bank that consumes the generic register-bus request produced by the APB4-to-register-bus bridge, and returns the ready, read-data and error responses to it.
- Holds four 32-bit CSRs: control, hardware status, interrupt status (W1C with hardware set) and interrupt enable.
- Drives a single level interrupt output.
- Sits directly downstream of the bridge, on the bridge's register-side interface.

Parameters:
- ADDR_WIDTH, 4, byte-address width of bus_addr; map decodes bus_addr[3:0].
- DATA_WIDTH, 32, register and bus data width; bus_wr_biten width is DATA_WIDTH/8.
- WAIT_CYCLES, 0, extra cycles between request accept and bus_ready (0..15).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- bus_req  in  1  request valid; held high by the bridge until bus_ready is seen.
- bus_req_is_wr  in  1  1 = write, 0 = read.
- bus_addr  in  ADDR_WIDTH  byte address.
- bus_wr_data  in  DATA_WIDTH  write data.
- bus_wr_biten  in  DATA_WIDTH/8  byte enables for writes.
- bus_ready  out  1  one-cycle response strobe.
- bus_rd_data  out  DATA_WIDTH  read data, valid while bus_ready=1, else 0.
- bus_err  out  1  error flag, valid while bus_ready=1, else 0.
- hw_status  in  DATA_WIDTH  live status value sampled on STATUS reads.
- hw_irq_set  in  DATA_WIDTH  per-bit set pulses into IRQ_STAT.
- ctrl_out  out  DATA_WIDTH  current CTRL register value.
- irq  out  1  registered OR of (IRQ_STAT & IRQ_EN).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: CTRL=0, IRQ_STAT=0, IRQ_EN=0, irq=0, bus_ready=0, bus_rd_data=0, bus_err=0. FSM goes to IDLE and the wait counter clears.
- Register map (byte addresses):
  - 0x0 CTRL, RW.
  - 0x4 STATUS, RO; reads return hw_status.
  - 0x8 IRQ_STAT, W1C.
  - 0xC IRQ_EN, RW.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If bus_req=1, accept: decode, perform the write or capture read data/err into response registers.
  - Go to WAIT if WAIT_CYCLES>0 (load counter with WAIT_CYCLES-1), else go to RESP.
- WAIT: decrement counter; go to RESP when counter=0.
- RESP:
  - bus_ready=1 for exactly one cycle, with captured rd_data/err.
  - Always return to IDLE; no request is accepted in RESP.
  - Rationale: bus_req is still high in this cycle and must not be executed twice.
- Latency: bus_ready is asserted 1+WAIT_CYCLES cycles after the accept cycle.
- Write side effects occur at the accept edge, never repeated for the same request.
- Read data is captured at accept. A STATUS read returns hw_status as of the accept cycle.
- Byte enables: for RW registers, byte k is updated only where bus_wr_biten[k]=1. For IRQ_STAT, W1C clears only bits in enabled bytes.
- Errors (bus_err=1 in RESP; no register changes; rd_data=0):
  - bus_addr[1:0] != 0 (misaligned), read or write.
  - Write to STATUS.
- Reads never have side effects, including IRQ_STAT.
- IRQ_STAT update each cycle: next = (cur & ~clr) | hw_irq_set, where clr is the accepted W1C mask. Hardware set wins over a same-cycle software clear of the same bit.
- irq is registered: it reflects IRQ_STAT/IRQ_EN one cycle after they change.
- bus_req dropping mid-WAIT (bridge reset): the response still completes. A reset of this block returns it to IDLE immediately with all reset values.
- Address bits above [3:0] are ignored (aliased).

Test Plan:
- Reset, then read 0x0, 0x8, 0xC with WAIT_CYCLES=0 -> each gives rd_data=0, err=0, bus_ready exactly 1 cycle, 1 cycle after accept.
- Write 0x0=0xA5A5_1234 with biten=4'b0101, starting from CTRL=0 -> ctrl_out=0x00A5_0034; read back equals 0x00A5_0034.
- Pulse hw_irq_set=0x0000_0009, write IRQ_EN=0x1 -> irq=1. Write 0x8=0x1 -> IRQ_STAT=0x8 and irq=0 one cycle after the clear.
- hw_irq_set bit 3 pulsed in the same cycle as a W1C of 0x8 -> IRQ_STAT bit 3 remains 1.
- Write to 0x4, and read of 0x2 -> bus_err=1, rd_data=0, no register change; hw_status=0xDEAD_BEEF read at 0x4 -> 0xDEAD_BEEF, err=0.
- WAIT_CYCLES=3, bus_req held high through the response -> bus_ready 4 cycles after accept, a single pulse, one write performed only. Reset asserted during WAIT -> no bus_ready, all outputs 0.
